multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle controller. One FSM sequences fetch, decode, execute, memory and writeback over several clock cycles, so that a single shared memory and a single ALU can serve every step.
- Adds a memory ready handshake, a parametrised memory timeout, and BNE/JAL support.
- Adds fault reporting for illegal opcodes and for memory timeouts.
- Sits between the instruction register/datapath and the unified memory port.

Parameters:
- MEM_TIMEOUT, 16, max cycles to wait for MemReady in any memory state before faulting; 0 disables the timeout.
- SUPPORT_BNE, 1, when 0, funct3=001 branches are illegal.
- ALUOP_W, 4, width of ALUOperation.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- OPCode  in  7  instruction[6:0], taken from the instruction register.
- funct3  in  3  instruction[14:12].
- funct7  in  7  instruction[31:25].
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory has completed the current access.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register (and OldPC) enable.
- ALUSrcA  out  2  ALU A select: 0=PC, 1=OldPC, 2=rs1.
- ALUSrcB  out  2  ALU B select: 0=rs2, 1=imm, 2=const 4.
- ResultSrc  out  2  result select: 0=ALUOut, 1=MemData, 2=ALU result.
- ALUOperation  out  ALUOP_W  0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
- RegWrite  out  1  register file write enable.
- InstrDone  out  1  one-cycle pulse in the last state of every instruction.
- Fault  out  1  sticky error flag.

Behaviour:
- States: RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JAL, ERROR.
- Reset (asynchronous): state=RST, timeout counter=0.
  - Every output is 0 while in RST.
  - RST always goes to FETCH on the next clock.
- FETCH:
  - Outputs: AdrSrc=0, MemRead=1, ALUSrcA=0, ALUSrcB=2, ALUOperation=ADD, ResultSrc=2.
  - On MemReady=1: IRWrite=1 and PCWrite=1 in the same cycle, then go to DECODE.
- DECODE:
  - Outputs: ALUSrcA=1, ALUSrcB=1, ALUOperation=ADD (precomputes the branch target into ALUOut).
  - Next state by OPCode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - anything else -> ERROR
- MEMADR:
  - Outputs: ALUSrcA=2, ALUSrcB=1, ALUOperation=ADD.
  - Next: MEMRD for a load, MEMWR for a store.
- MEMRD:
  - Outputs: AdrSrc=1, MemRead=1.
  - Waits for MemReady, then goes to MEMWB.
- MEMWB:
  - Outputs: ResultSrc=1, RegWrite=1, InstrDone=1.
  - Next: FETCH.
- MEMWR:
  - Outputs: AdrSrc=1, MemWrite=1. MemWrite stays high until MemReady.
  - On MemReady: InstrDone=1, then FETCH.
- EXECR / EXECI:
  - Outputs: ALUSrcA=2. ALUSrcB=0 in EXECR, 1 in EXECI.
  - ALUOperation comes from the decoder.
  - Next: ALUWB.
- ALUWB:
  - Outputs: ResultSrc=0, RegWrite=1, InstrDone=1.
  - Next: FETCH.
- BRANCH:
  - Outputs: ALUSrcA=2, ALUSrcB=0, ALUOperation=SUB, ResultSrc=0, InstrDone=1.
  - PCWrite is combinational:
    - funct3=000 (BEQ): PCWrite = Zero.
    - funct3=001 (BNE, when SUPPORT_BNE=1): PCWrite = ~Zero.
  - Other funct3 values are caught in DECODE and go to ERROR.
  - Next: FETCH.
- JAL:
  - Step 1: ALUSrcA=1, ALUSrcB=2, ALUOperation=ADD, ResultSrc=0, PCWrite=1 (PC <= ALUOut, which holds the target).
  - Step 2: then go to ALUWB to write the link value.
  - The datapath latches OldPC+4 into ALUOut in this same cycle.
- ALU decoder:
  - In EXECR, keyed on {funct7[5], funct3}:
    - 0/000 ADD
    - 1/000 SUB
    - x/111 AND
    - x/110 OR
    - any other combination -> ERROR (next state instead of ALUWB)
  - In EXECI, funct7 is ignored.
- Timeout counter:
  - Increments each cycle that FETCH, MEMRD or MEMWR waits with MemReady=0.
  - Clears on leaving those states.
  - When the count reaches MEM_TIMEOUT and MemReady is still 0, go to ERROR.
  - MemReady in that same cycle wins over the timeout.
- ERROR:
  - All enables are 0 and Fault=1.
  - ERROR is absorbing; only reset leaves it.
- Reset asserted mid-instruction: immediate return to RST with no further write enables.
- PCWrite/RegWrite/MemWrite are never high in the same cycle, except PCWrite and IRWrite together in FETCH.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state_t enum
  - opcode constants: OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL
  - ALU op constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB
  - mux select constants
- Sub-module mc_alu_decoder (combinational):
  - Inputs: funct7[5], funct3, a mode select.
  - Outputs: ALUOperation and an illegal flag.
- FSM, timeout counter and output decode stay in the top module.

Test Plan:
- add, OPCode=0110011 funct3=000 funct7=0000000, MemReady tied 1:
  - States go RST->FETCH->DECODE->EXECR->ALUWB->FETCH.
  - ALUOperation=0010 in EXECR.
  - RegWrite=1 and InstrDone=1 only in ALUWB.
- sub: funct7=0100000 -> ALUOperation=0110.
- lw, OPCode=0000011, MemReady held low for 3 cycles in MEMRD:
  - MemRead stays 1 and AdrSrc=1 for 4 cycles.
  - Then MEMWB with ResultSrc=1 and RegWrite=1.
  - Total is 5 states plus the wait cycles.
- beq, OPCode=1100011 funct3=000:
  - Zero=1 -> PCWrite=1 in BRANCH.
  - Zero=0 -> PCWrite=0.
  - Repeat with funct3=001 and check the inverted result.
- MEM_TIMEOUT=4, MemReady held 0 in FETCH:
  - ERROR is entered after 4 wait cycles and Fault=1.
  - The state stays in ERROR with MemReady later 1.
  - Asserting reset clears Fault.
- Illegal OPCode=1111111:
  - DECODE->ERROR, and no RegWrite, MemWrite or PCWrite is ever asserted.
  - Also: reset asserted during MEMWR forces all outputs to 0 on the same edge.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle controller.
// States, opcodes, ALU operation codes and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_ERROR
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction fields and status in, datapath/memory controls out.
// master = controller side, slave = datapath side.
interface multicycle_control_unit_if #(
  parameter int ALUOP_W = 4
);
  logic [6:0]         OPCode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic               Zero;
  logic               MemReady;
  logic               PCWrite;
  logic               AdrSrc;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ResultSrc;
  logic [ALUOP_W-1:0] ALUOperation;
  logic               RegWrite;
  logic               InstrDone;
  logic               Fault;

  modport master (
    input  OPCode, funct3, funct7, Zero, MemReady,
    output PCWrite, AdrSrc, MemRead, MemWrite, IRWrite,
    output ALUSrcA, ALUSrcB, ResultSrc, ALUOperation,
    output RegWrite, InstrDone, Fault
  );

  modport slave (
    output OPCode, funct3, funct7, Zero, MemReady,
    input  PCWrite, AdrSrc, MemRead, MemWrite, IRWrite,
    input  ALUSrcA, ALUSrcB, ResultSrc, ALUOperation,
    input  RegWrite, InstrDone, Fault
  );
endinterface

// File: rtl/mc_alu_decoder.sv
// ALU operation decode for register and immediate arithmetic.
// imode=1 ignores funct7 (no SUB form for immediates).
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic       f7b5,
  input  logic [2:0] funct3,
  input  logic       imode,
  output logic [3:0] aluop,
  output logic       illegal
);

  always_comb begin
    aluop   = ALU_ADD;
    illegal = 1'b0;
    unique case (1'b1)
      (funct3 == 3'b000) && (imode || !f7b5):
        aluop = ALU_ADD;
      (funct3 == 3'b000) && !imode && f7b5:
        aluop = ALU_SUB;
      (funct3 == 3'b111):
        aluop = ALU_AND;
      (funct3 == 3'b110):
        aluop = ALU_OR;
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32 subset controller: FSM, memory wait timeout
// and output decode sharing one memory port and one ALU.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter bit SUPPORT_BNE = 1'b1,
  parameter int ALUOP_W     = 4
) (
  input logic                       clk,
  input logic                       reset,
  multicycle_control_unit_if.master bus
);

  localparam int CW =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          waiting;
  logic          tmo;
  logic          br_ok;
  logic          imode;
  logic [3:0]    dec_op;
  logic          dec_ill;
  logic          unused_ok;

  assign unused_ok =
    ^{bus.funct7[6], bus.funct7[4:0]};

  assign imode = (state == S_EXECI);

  mc_alu_decoder u_dec (
    .f7b5    (bus.funct7[5]),
    .funct3  (bus.funct3),
    .imode   (imode),
    .aluop   (dec_op),
    .illegal (dec_ill)
  );

  assign waiting =
    ((state == S_FETCH) || (state == S_MEMRD) ||
     (state == S_MEMWR)) && !bus.MemReady;

  // Last permitted wait cycle: the count would reach the limit.
  assign tmo = (MEM_TIMEOUT > 0) && waiting &&
    (cnt == CW'(MEM_TIMEOUT - 1));

  assign br_ok = (bus.funct3 == 3'b000) ||
    (SUPPORT_BNE && (bus.funct3 == 3'b001));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RST;
      cnt   <= '0;
    end else begin
      cnt <= (waiting && (MEM_TIMEOUT > 0)) ?
        cnt + 1'b1 : '0;
      unique case (state)
        S_RST: state <= S_FETCH;
        S_FETCH:
          if (bus.MemReady) state <= S_DECODE;
          else if (tmo)     state <= S_ERROR;
        S_DECODE:
          case (bus.OPCode)
            OP_LOAD,
            OP_STORE:  state <= S_MEMADR;
            OP_RTYPE:  state <= S_EXECR;
            OP_ITYPE:  state <= S_EXECI;
            OP_BRANCH:
              state <= br_ok ? S_BRANCH : S_ERROR;
            OP_JAL:    state <= S_JAL;
            default:   state <= S_ERROR;
          endcase
        S_MEMADR:
          state <= (bus.OPCode == OP_LOAD) ?
            S_MEMRD : S_MEMWR;
        S_MEMRD:
          if (bus.MemReady) state <= S_MEMWB;
          else if (tmo)     state <= S_ERROR;
        S_MEMWR:
          if (bus.MemReady) state <= S_FETCH;
          else if (tmo)     state <= S_ERROR;
        S_EXECR,
        S_EXECI:
          state <= dec_ill ? S_ERROR : S_ALUWB;
        S_MEMWB,
        S_ALUWB,
        S_BRANCH: state <= S_FETCH;
        S_JAL:    state <= S_ALUWB;
        S_ERROR:  state <= S_ERROR;
        default:  state <= S_ERROR;
      endcase
    end
  end

  always_comb begin
    bus.PCWrite      = 1'b0;
    bus.AdrSrc       = 1'b0;
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.ALUSrcA      = SRCA_PC;
    bus.ALUSrcB      = SRCB_RS2;
    bus.ResultSrc    = RES_ALUOUT;
    bus.ALUOperation = '0;
    bus.RegWrite     = 1'b0;
    bus.InstrDone    = 1'b0;
    bus.Fault        = 1'b0;
    case (state)
      S_FETCH: begin
        bus.MemRead      = 1'b1;
        bus.ALUSrcB      = SRCB_FOUR;
        bus.ALUOperation = ALUOP_W'(ALU_ADD);
        bus.ResultSrc    = RES_ALU;
        bus.IRWrite      = bus.MemReady;
        bus.PCWrite      = bus.MemReady;
      end
      S_DECODE: begin
        bus.ALUSrcA      = SRCA_OLDPC;
        bus.ALUSrcB      = SRCB_IMM;
        bus.ALUOperation = ALUOP_W'(ALU_ADD);
      end
      S_MEMADR: begin
        bus.ALUSrcA      = SRCA_RS1;
        bus.ALUSrcB      = SRCB_IMM;
        bus.ALUOperation = ALUOP_W'(ALU_ADD);
      end
      S_MEMRD: begin
        bus.AdrSrc  = 1'b1;
        bus.MemRead = 1'b1;
      end
      S_MEMWB: begin
        bus.ResultSrc = RES_MEM;
        bus.RegWrite  = 1'b1;
        bus.InstrDone = 1'b1;
      end
      S_MEMWR: begin
        bus.AdrSrc    = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.InstrDone = bus.MemReady;
      end
      S_EXECR,
      S_EXECI: begin
        bus.ALUSrcA      = SRCA_RS1;
        bus.ALUSrcB      = imode ? SRCB_IMM : SRCB_RS2;
        bus.ALUOperation = ALUOP_W'(dec_op);
      end
      S_ALUWB: begin
        bus.RegWrite  = 1'b1;
        bus.InstrDone = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA      = SRCA_RS1;
        bus.ALUOperation = ALUOP_W'(ALU_SUB);
        bus.InstrDone    = 1'b1;
        bus.PCWrite      = (bus.funct3 == 3'b000) ?
          bus.Zero : ~bus.Zero;
      end
      // ALUOut holds the target from DECODE; ALU forms OldPC+4.
      S_JAL: begin
        bus.ALUSrcA      = SRCA_OLDPC;
        bus.ALUSrcB      = SRCB_FOUR;
        bus.ALUOperation = ALUOP_W'(ALU_ADD);
        bus.PCWrite      = 1'b1;
      end
      S_ERROR: bus.Fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-cycle vector table
// through an expected-output queue, plus corner sequences.
module tb_multicycle_control_unit;

  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;

  localparam logic [6:0] P_LD  = 7'b0000011;
  localparam logic [6:0] P_ST  = 7'b0100011;
  localparam logic [6:0] P_R   = 7'b0110011;
  localparam logic [6:0] P_I   = 7'b0010011;
  localparam logic [6:0] P_BR  = 7'b1100011;
  localparam logic [6:0] P_JAL = 7'b1101111;
  localparam logic [6:0] P_BAD = 7'b1111111;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic [3:0] aluop;
    logic       rw;
    logic       done;
    logic       fault;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z;
    logic       rdy;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   npass = 0;
  int   nchk = 0;

  vec_t tbl[$];
  out_t sb[$];

  logic [6:0] c_op = '0;
  logic [2:0] c_f3 = '0;
  logic [6:0] c_f7 = '0;
  logic       c_z = 1'b0;

  multicycle_control_unit_if #(.ALUOP_W(4)) bus ();

  multicycle_control_unit #(
    .MEM_TIMEOUT (4),
    .SUPPORT_BNE (1'b1),
    .ALUOP_W     (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic out_t o_rst();
    out_t o = '0;
    return o;
  endfunction

  function automatic out_t o_fetch(logic r);
    out_t o = '0;
    o.mrd = 1'b1; o.srcb = 2'd2; o.res = 2'd2;
    o.aluop = A_ADD; o.irw = r; o.pcw = r;
    return o;
  endfunction

  function automatic out_t o_dec();
    out_t o = '0;
    o.srca = 2'd1; o.srcb = 2'd1; o.aluop = A_ADD;
    return o;
  endfunction

  function automatic out_t o_madr();
    out_t o = '0;
    o.srca = 2'd2; o.srcb = 2'd1; o.aluop = A_ADD;
    return o;
  endfunction

  function automatic out_t o_mrd();
    out_t o = '0;
    o.adr = 1'b1; o.mrd = 1'b1;
    return o;
  endfunction

  function automatic out_t o_mwb();
    out_t o = '0;
    o.res = 2'd1; o.rw = 1'b1; o.done = 1'b1;
    return o;
  endfunction

  function automatic out_t o_mwr(logic r);
    out_t o = '0;
    o.adr = 1'b1; o.mwr = 1'b1; o.done = r;
    return o;
  endfunction

  function automatic out_t o_ex(logic imm, logic [3:0] a);
    out_t o = '0;
    o.srca = 2'd2; o.srcb = imm ? 2'd1 : 2'd0;
    o.aluop = a;
    return o;
  endfunction

  function automatic out_t o_awb();
    out_t o = '0;
    o.rw = 1'b1; o.done = 1'b1;
    return o;
  endfunction

  function automatic out_t o_br(logic t);
    out_t o = '0;
    o.srca = 2'd2; o.aluop = A_SUB;
    o.done = 1'b1; o.pcw = t;
    return o;
  endfunction

  function automatic out_t o_jal();
    out_t o = '0;
    o.srca = 2'd1; o.srcb = 2'd2; o.aluop = A_ADD;
    o.pcw = 1'b1;
    return o;
  endfunction

  function automatic out_t o_err();
    out_t o = '0;
    o.fault = 1'b1;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.pcw = bus.PCWrite;     o.adr = bus.AdrSrc;
    o.mrd = bus.MemRead;     o.mwr = bus.MemWrite;
    o.irw = bus.IRWrite;     o.srca = bus.ALUSrcA;
    o.srcb = bus.ALUSrcB;    o.res = bus.ResultSrc;
    o.aluop = bus.ALUOperation;
    o.rw = bus.RegWrite;     o.done = bus.InstrDone;
    o.fault = bus.Fault;
    return o;
  endfunction

  task automatic ins(logic [6:0] op, logic [2:0] f3,
                     logic [6:0] f7, logic z);
    c_op = op; c_f3 = f3; c_f7 = f7; c_z = z;
  endtask

  task automatic v(string n, logic r, logic rdy, out_t e);
    vec_t x;
    x.name = n; x.rst = r; x.op = c_op; x.f3 = c_f3;
    x.f7 = c_f7; x.z = c_z; x.rdy = rdy; x.exp = e;
    tbl.push_back(x);
  endtask

  task automatic check(string n, out_t got, out_t want);
    int en;
    nchk++;
    if (got === want) npass++;
    else $display("FAIL %s: got %h want %h", n, got, want);
    en = int'(got.pcw) + int'(got.rw) + int'(got.mwr);
    nchk++;
    if (en <= 1) npass++;
    else $display("FAIL %s_excl: got %0d enables want <=1",
                  n, en);
  endtask

  task automatic step(vec_t x);
    out_t e;
    @(posedge clk);
    #1;
    reset = x.rst;
    bus.OPCode = x.op; bus.funct3 = x.f3;
    bus.funct7 = x.f7; bus.Zero = x.z;
    bus.MemReady = x.rdy;
    sb.push_back(x.exp);
    @(negedge clk);
    e = sb.pop_front();
    check(x.name, sample(), e);
  endtask

  initial begin
    vec_t hv;
    bus.OPCode = '0; bus.funct3 = '0; bus.funct7 = '0;
    bus.Zero = 1'b0; bus.MemReady = 1'b0;

    ins(P_R, 3'b000, 7'b0000000, 1'b0);
    v("rst", 1, 1, o_rst());
    v("rst_rel", 0, 1, o_rst());
    v("add_f", 0, 1, o_fetch(1));
    v("add_d", 0, 1, o_dec());
    v("add_x", 0, 1, o_ex(0, A_ADD));
    v("add_wb", 0, 1, o_awb());
    ins(P_R, 3'b000, 7'b0100000, 1'b0);
    v("sub_f", 0, 1, o_fetch(1));
    v("sub_d", 0, 1, o_dec());
    v("sub_x", 0, 1, o_ex(0, A_SUB));
    v("sub_wb", 0, 1, o_awb());
    ins(P_LD, 3'b010, 7'b0, 1'b0);
    v("lw_f", 0, 1, o_fetch(1));
    v("lw_d", 0, 1, o_dec());
    v("lw_a", 0, 1, o_madr());
    for (int i = 0; i < 3; i++)
      v("lw_wait", 0, 0, o_mrd());
    v("lw_rd", 0, 1, o_mrd());
    v("lw_wb", 0, 1, o_mwb());
    for (int k = 0; k < 4; k++) begin
      ins(P_BR, k[1] ? 3'b001 : 3'b000, 7'b0, ~k[0]);
      v("br_f", 0, 1, o_fetch(1));
      v("br_d", 0, 1, o_dec());
      v(k[1] ? "bne" : "beq", 0, 1, o_br(k[1] ^ ~k[0]));
    end
    ins(P_ST, 3'b010, 7'b0, 1'b0);
    v("sw_f", 0, 1, o_fetch(1));
    v("sw_d", 0, 1, o_dec());
    v("sw_a", 0, 1, o_madr());
    v("sw_wait", 0, 0, o_mwr(0));
    v("sw_wr", 0, 1, o_mwr(1));
    ins(P_JAL, 3'b000, 7'b0, 1'b0);
    v("jal_f", 0, 1, o_fetch(1));
    v("jal_d", 0, 1, o_dec());
    v("jal_j", 0, 1, o_jal());
    v("jal_wb", 0, 1, o_awb());
    ins(P_I, 3'b000, 7'b0100000, 1'b0);
    v("addi_f", 0, 1, o_fetch(1));
    v("addi_d", 0, 1, o_dec());
    v("addi_x", 0, 1, o_ex(1, A_ADD));
    v("addi_wb", 0, 1, o_awb());
    ins(P_R, 3'b110, 7'b0, 1'b0);
    v("or_f", 0, 1, o_fetch(1));
    v("or_d", 0, 1, o_dec());
    v("or_x", 0, 1, o_ex(0, A_OR));
    v("or_wb", 0, 1, o_awb());
    ins(P_I, 3'b111, 7'b0, 1'b0);
    v("andi_f", 0, 1, o_fetch(1));
    v("andi_d", 0, 1, o_dec());
    v("andi_x", 0, 1, o_ex(1, A_AND));
    v("andi_wb", 0, 1, o_awb());
    ins(P_BR, 3'b101, 7'b0, 1'b0);
    v("bge_f", 0, 1, o_fetch(1));
    v("bge_d", 0, 1, o_dec());
    v("bge_err", 0, 1, o_err());
    v("rst2", 1, 1, o_rst());
    v("rst2_rel", 0, 1, o_rst());
    ins(P_R, 3'b000, 7'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      v("tmo_wait", 0, 0, o_fetch(0));
    v("tmo_err", 0, 1, o_err());
    v("tmo_stay", 0, 1, o_err());
    v("rst3", 1, 1, o_rst());
    v("rst3_rel", 0, 1, o_rst());
    ins(P_BAD, 3'b000, 7'b0, 1'b0);
    v("bad_f", 0, 1, o_fetch(1));
    v("bad_d", 0, 1, o_dec());
    v("bad_err", 0, 1, o_err());
    v("bad_stay", 0, 1, o_err());
    v("rst4", 1, 1, o_rst());
    v("rst4_rel", 0, 1, o_rst());

    foreach (tbl[i]) step(tbl[i]);

    // MemReady on the last allowed wait cycle beats the timeout.
    tbl.delete();
    ins(P_R, 3'b111, 7'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      v("win_wait", 0, 0, o_fetch(0));
    v("win_f", 0, 1, o_fetch(1));
    v("win_d", 0, 1, o_dec());
    v("win_x", 0, 1, o_ex(0, A_AND));
    ins(P_ST, 3'b010, 7'b0, 1'b0);
    v("win_wb", 0, 1, o_awb());
    v("rw_f", 0, 1, o_fetch(1));
    v("rw_d", 0, 1, o_dec());
    v("rw_a", 0, 1, o_madr());
    v("rw_wait", 0, 0, o_mwr(0));
    foreach (tbl[i]) step(tbl[i]);

    // Reset pulled in the middle of a MEMWR wait.
    #2;
    reset = 1'b1;
    #1;
    check("rst_in_memwr", sample(), o_rst());
    @(posedge clk);
    #1;
    check("rst_held", sample(), o_rst());
    hv.name = "rst_rel5"; hv.rst = 1'b0; hv.op = P_R;
    hv.f3 = 3'b000; hv.f7 = 7'b0; hv.z = 1'b0;
    hv.rdy = 1'b1; hv.exp = o_rst();
    step(hv);
    hv.name = "post_f"; hv.exp = o_fetch(1);
    step(hv);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
